// File: rtl/io_uart_drain.sv
// Output-buffer drain: pops bytes from the core's IO output buffer and sends them as UART frames, 8N1, LSB first.
// Define IO_UART_DRAIN_PARITY_EN to add an even-parity bit, giving 8E1 frames.
module io_uart_drain #(
    parameter int CLKS_PER_BIT = 868,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_enable,
    output logic                   io_output_en,
    input  logic [7:0]             io_output_data,
    input  logic [31:0]            io_buffer_size_avai,
    output logic                   tx,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] bytes_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

    state_t                 state_q, state_d;
    logic [15:0]            bit_cnt_q, bit_cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [7:0]             hold_data_q, hold_data_d;
    logic                   cooldown_q, cooldown_d;
    logic                   tx_q, tx_d;
    logic [COUNT_WIDTH-1:0] bytes_sent_q, bytes_sent_d;
`ifdef IO_UART_DRAIN_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    logic pop;
    logic bit_done;

    // Occupancy lags a pop by one cycle, so the cycle after a strobe is always skipped.
    assign pop      = !hold_valid_q && tx_enable && (io_buffer_size_avai != 32'd0) && !cooldown_q;
    assign bit_done = (bit_cnt_q == LAST_TICK);

    always_comb begin
        cooldown_d   = pop;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        bit_cnt_d    = bit_cnt_q + 16'd1;
        bytes_sent_d = bytes_sent_q;
`ifdef IO_UART_DRAIN_PARITY_EN
        parity_d     = parity_q;
`endif

        if (pop) begin
            hold_valid_d = 1'b1;
            hold_data_d  = io_output_data;
        end

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = 16'd0;
                if (hold_valid_q) begin
                    shift_d      = hold_data_q;
                    hold_valid_d = 1'b0;
                    state_d      = S_START;
`ifdef IO_UART_DRAIN_PARITY_EN
                    parity_d     = ^hold_data_q;
`endif
                end
            end
            S_START: begin
                if (bit_done) begin
                    bit_cnt_d = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = 16'd0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef IO_UART_DRAIN_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef IO_UART_DRAIN_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    bit_cnt_d = 16'd0;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    bit_cnt_d    = 16'd0;
                    bytes_sent_d = bytes_sent_q + 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                bit_cnt_d = 16'd0;
                state_d   = S_IDLE;
            end
        endcase

        // The line level is decoded from the next state so that tx is registered yet changes in step with the FSM.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef IO_UART_DRAIN_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'd0;
            cooldown_q   <= 1'b0;
            tx_q         <= 1'b1;
            bytes_sent_q <= '0;
`ifdef IO_UART_DRAIN_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            cooldown_q   <= cooldown_d;
            tx_q         <= tx_d;
            bytes_sent_q <= bytes_sent_d;
`ifdef IO_UART_DRAIN_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign io_output_en = pop;
    assign tx           = tx_q;
    assign busy         = (state_q != S_IDLE) | hold_valid_q;
    assign bytes_sent   = bytes_sent_q;

endmodule

// File: tb/tb_io_uart_drain.sv
// Directed self-checking bench for io_uart_drain at CLKS_PER_BIT=4, with a small FIFO model standing in for the output buffer.
// Parity checks are active when IO_UART_DRAIN_PARITY_EN is defined.
module tb_io_uart_drain;

    localparam int CPB = 4;
`ifdef IO_UART_DRAIN_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_enable = 1'b1;
    logic        io_output_en;
    logic [7:0]  io_output_data;
    logic [31:0] io_buffer_size_avai;
    logic        tx;
    logic        busy;
    logic [31:0] bytes_sent;

    int total = 0;
    int bad = 0;

    logic [7:0] buf_mem [16];
    int head = 0;
    int tail = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int adj_cnt = 0;
    int strobe_cyc = 0;
    logic prev_en = 1'b0;

    io_uart_drain #(.CLKS_PER_BIT(CPB), .COUNT_WIDTH(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .tx_enable           (tx_enable),
        .io_output_en        (io_output_en),
        .io_output_data      (io_output_data),
        .io_buffer_size_avai (io_buffer_size_avai),
        .tx                  (tx),
        .busy                (busy),
        .bytes_sent          (bytes_sent)
    );

    always #5 clk = ~clk;

    assign io_buffer_size_avai = 32'(tail - head);
    assign io_output_data      = buf_mem[head % 16];

    // Buffer model: occupancy drops the cycle after a pop edge; strobes are logged for the checks.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_en <= io_output_en;
        if (io_output_en) begin
            head       <= head + 1;
            strobe_cnt <= strobe_cnt + 1;
            strobe_cyc <= cyc;
            if (prev_en) adj_cnt <= adj_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] b);
        buf_mem[tail % 16] = b;
        tail = tail + 1;
    endtask

    // Waits for a start bit, then checks every cycle of the frame against the expected bit pattern.
    task automatic check_frame(input logic [7:0] b, input string tag, output int waited, output int start_c);
        logic [10:0] bits;
        logic [10:0] badbit;
        logic [10:0] gotbit;
        bit found;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
`ifdef IO_UART_DRAIN_PARITY_EN
        bits[9] = ^b;
`endif
        badbit = '0;
        gotbit = '0;
        found = 1'b0;
        waited = 0;
        start_c = 0;
        while (!found && waited < 300) begin
            @(negedge clk);
            waited++;
            if (tx === 1'b0) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL %s start: got no start bit want start within 300 cycles", tag);
        end else begin
            start_c = cyc;
            for (int k = 0; k < NBITS * CPB; k++) begin
                if (k > 0) @(negedge clk);
                if (tx !== bits[k / CPB]) begin
                    badbit[k / CPB] = 1'b1;
                    gotbit[k / CPB] = tx;
                end
            end
            for (int i = 0; i < NBITS; i++) begin
                total++;
                if (badbit[i]) begin
                    bad++;
                    $display("[TB] FAIL %s bit%0d: got tx=%0b want %0b", tag, i, gotbit[i], bits[i]);
                end
            end
        end
    endtask

    task automatic check_done(input string tag, input logic [31:0] want);
        @(negedge clk);
        total++;
        if (bytes_sent !== want) begin
            bad++;
            $display("[TB] FAIL %s bytes_sent: got %0d want %0d", tag, bytes_sent, want);
        end
        total++;
        if (tx !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s idle_tx: got %0b want 1", tag, tx);
        end
    endtask

    task automatic test_reset();
        int e_tx, e_en, e_busy, e_cnt;
        e_tx = 0; e_en = 0; e_busy = 0; e_cnt = 0;
        repeat (3) @(negedge clk);
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || bytes_sent !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_held: got tx=%0b busy=%0b cnt=%0d want 1 0 0", tx, busy, bytes_sent);
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) e_tx++;
            if (io_output_en !== 1'b0) e_en++;
            if (busy !== 1'b0) e_busy++;
            if (bytes_sent !== 32'd0) e_cnt++;
        end
        total++; if (e_tx != 0)   begin bad++; $display("[TB] FAIL reset_tx: got %0d bad cycles want 0", e_tx); end
        total++; if (e_en != 0)   begin bad++; $display("[TB] FAIL reset_strobe: got %0d bad cycles want 0", e_en); end
        total++; if (e_busy != 0) begin bad++; $display("[TB] FAIL reset_busy: got %0d bad cycles want 0", e_busy); end
        total++; if (e_cnt != 0)  begin bad++; $display("[TB] FAIL reset_count: got %0d bad cycles want 0", e_cnt); end
    endtask

    task automatic test_single();
        int w, sc, s0;
        logic [31:0] b0;
        s0 = strobe_cnt;
        b0 = bytes_sent;
        push(8'hA5);
        check_frame(8'hA5, "single", w, sc);
        total++;
        if (sc - strobe_cyc != 2) begin
            bad++;
            $display("[TB] FAIL single_latency: got %0d want 2", sc - strobe_cyc);
        end
        check_done("single", b0 + 1);
        repeat (20) @(negedge clk);
        total++;
        if (strobe_cnt - s0 != 1) begin
            bad++;
            $display("[TB] FAIL single_strobes: got %0d want 1", strobe_cnt - s0);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_busy: got %0b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int w, sc, s0, a0;
        logic [31:0] b0;
        s0 = strobe_cnt;
        a0 = adj_cnt;
        b0 = bytes_sent;
        push(8'h01); push(8'h02); push(8'h03);
        check_frame(8'h01, "burst0", w, sc);
        check_done("burst0", b0 + 1);
        check_frame(8'h02, "burst1", w, sc);
        total++; if (w != 1) begin bad++; $display("[TB] FAIL burst1_gap: got %0d want 1", w); end
        check_done("burst1", b0 + 2);
        check_frame(8'h03, "burst2", w, sc);
        total++; if (w != 1) begin bad++; $display("[TB] FAIL burst2_gap: got %0d want 1", w); end
        check_done("burst2", b0 + 3);
        repeat (10) @(negedge clk);
        total++; if (strobe_cnt - s0 != 3) begin bad++; $display("[TB] FAIL burst_strobes: got %0d want 3", strobe_cnt - s0); end
        total++; if (adj_cnt != a0) begin bad++; $display("[TB] FAIL burst_adjacent: got %0d want %0d", adj_cnt, a0); end
    endtask

    task automatic test_flow_control();
        int w, sc, s0, wb;
        logic [31:0] b0;
        s0 = strobe_cnt;
        b0 = bytes_sent;
        push(8'h11); push(8'h22); push(8'h33);
        fork
            check_frame(8'h11, "flow0", w, sc);
            begin
                wb = 0;
                while (tx !== 1'b0 && wb < 300) begin
                    @(negedge clk);
                    wb++;
                end
                repeat (5) @(negedge clk);
                tx_enable = 1'b0;
            end
        join
        check_done("flow0", b0 + 1);
        check_frame(8'h22, "flow1", w, sc);
        check_done("flow1", b0 + 2);
        repeat (60) @(negedge clk);
        total++; if (strobe_cnt - s0 != 2) begin bad++; $display("[TB] FAIL flow_paused_strobes: got %0d want 2", strobe_cnt - s0); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flow_paused_busy: got %0b want 0", busy); end
        total++; if (io_buffer_size_avai !== 32'd1) begin bad++; $display("[TB] FAIL flow_paused_avail: got %0d want 1", io_buffer_size_avai); end
        tx_enable = 1'b1;
        check_frame(8'h33, "flow2", w, sc);
        total++; if (w != 2) begin bad++; $display("[TB] FAIL flow_resume_latency: got %0d want 2", w); end
        check_done("flow2", b0 + 3);
    endtask

    task automatic test_mid_reset();
        int wb, s0, lows;
        s0 = strobe_cnt;
        push(8'hA5);
        wb = 0;
        while (tx !== 1'b0 && wb < 300) begin
            @(negedge clk);
            wb++;
        end
        repeat (17) @(negedge clk);
        total++; if (tx !== 1'b0) begin bad++; $display("[TB] FAIL midreset_before: got tx=%0b want 0", tx); end
        reset = 1'b1;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL midreset_tx: got %0b want 1", tx); end
        total++; if (busy !== 1'b0 || bytes_sent !== 32'd0 || io_output_en !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_state: got busy=%0b cnt=%0d en=%0b want 0 0 0", busy, bytes_sent, io_output_en);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        total++; if (lows != 0) begin bad++; $display("[TB] FAIL midreset_resend: got %0d low cycles want 0", lows); end
        total++; if (strobe_cnt - s0 != 1 || bytes_sent !== 32'd0) begin
            bad++;
            $display("[TB] FAIL midreset_after: got strobes=%0d cnt=%0d want 1 0", strobe_cnt - s0, bytes_sent);
        end
    endtask

`ifdef IO_UART_DRAIN_PARITY_EN
    task automatic test_parity();
        int w, sc;
        logic [31:0] b0;
        b0 = bytes_sent;
        push(8'h07);
        check_frame(8'h07, "parity07", w, sc);
        check_done("parity07", b0 + 1);
        push(8'h03);
        check_frame(8'h03, "parity03", w, sc);
        check_done("parity03", b0 + 2);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flow_control();
        test_mid_reset();
`ifdef IO_UART_DRAIN_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_uart_drain.md
# io_uart_drain

Consumer end of the core's memory-mapped output IO port. Watches the unified memory's output buffer occupancy, pops bytes one at a time with a single-cycle `io_output_en` strobe, and serializes each byte onto a UART line (8N1, LSB first). Sits at the top level beside the core, wired directly to `io_output_en`, `io_output_data` and `io_buffer_size_avai`. A one-byte holding register overlaps the next fetch with the current frame.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit. Legal range 2..65535.
- `COUNT_WIDTH`, default 32: width of `bytes_sent`.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `tx_enable` input 1: flow control; when low, no new pop is issued (frames in flight complete).
- `io_output_en` output 1: one-cycle pop strobe to the output buffer.
- `io_output_data` input 8: head byte of the buffer, valid combinationally whenever `io_buffer_size_avai != 0`.
- `io_buffer_size_avai` input 32: bytes currently held in the buffer; updates the cycle after a pop edge.
- `tx` output 1: UART serial line, idle high.
- `busy` output 1: high while a frame is on the line or the holding register is full.
- `bytes_sent` output COUNT_WIDTH: frames completed since reset; wraps modulo 2^COUNT_WIDTH.

## Operation

- Fetch side:
  - `hold_valid` flag plus 8-bit `hold_data`.
  - When `hold_valid==0`, `tx_enable==1`, `io_buffer_size_avai!=0` and no cooldown, assert `io_output_en` for exactly one cycle.
  - In that same cycle, capture `io_output_data` into `hold_data` and set `hold_valid` at the edge.
  - The following cycle is a mandatory cooldown with no strobe, because occupancy is stale. At most one pop every 2 cycles.
- TX FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: `tx=1`. If `hold_valid`, load shift register from `hold_data`, clear `hold_valid`, go to START.
  - START: `tx=0` for one bit period, then DATA.
  - DATA: `tx=shift[0]`. Shift right each bit period. After bit 7, go to PARITY or STOP.
  - STOP: `tx=1` for one bit period, increment `bytes_sent`, then IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1 and resets on every state entry. Each bit is exactly CLKS_PER_BIT cycles.
- Because clearing `hold_valid` in IDLE frees the holding register, the next byte can be fetched during the current frame.
- `busy = (state != IDLE) | hold_valid`.
- Dropping `tx_enable` mid-frame: the current frame and any already-held byte still transmit; only further pops stop.
- If `io_buffer_size_avai` reads 0, no strobe is issued, ever.

## Timing

- Reset values: `tx=1`, `io_output_en=0`, `busy=0`, `bytes_sent=0`, state IDLE, `hold_valid=0`, cooldown clear.
- Latency:
  - Pop strobe at cycle N (buffer nonempty, idle): `hold_valid` is high at N+1.
  - START begins at N+2, so the `tx` falling edge is 2 cycles after the strobe.
  - Frame length is 10×CLKS_PER_BIT cycles, or 11× with parity.
  - `bytes_sent` increments on the edge leaving STOP.
- Back-to-back traffic: START of byte k+1 immediately follows STOP of byte k, one IDLE cycle between them (stop bit lasts CLKS_PER_BIT cycles plus 1 IDLE cycle).
- Reset asserted mid-frame: `tx` goes high asynchronously. The held byte is discarded (already popped, not retransmitted).

## Configuration

- `IO_UART_DRAIN_PARITY_EN`:
  - Defined: PARITY state is compiled in. It emits the even-parity bit (XOR of the 8 data bits) for one bit period between DATA bit 7 and STOP. Frame is 11 bit periods.
  - Undefined: DATA goes straight to STOP. Frame is 10 bit periods (8N1).

## Test plan

- Reset check, CLKS_PER_BIT=4: hold `reset` high, then release with `io_buffer_size_avai=0` → `tx=1`, `io_output_en=0`, `busy=0`, `bytes_sent=0` for 100 cycles.
- Single byte, CLKS_PER_BIT=4: buffer holds 0xA5 → exactly one 1-cycle strobe. `tx` sequence per 4 cycles is 0,1,0,1,0,0,1,0,1,1. `bytes_sent=1` after 40 cycles. No further strobes.
- Burst, CLKS_PER_BIT=4: buffer model holds 0x01,0x02,0x03 → three strobes, never in adjacent cycles. Frames are separated by exactly 1 idle cycle. `bytes_sent=3`.
- Flow control: drop `tx_enable` 5 cycles into the first frame of a 3-byte burst → the in-flight frame and the held byte complete, no third strobe. Raising `tx_enable` resumes with byte 3.
- Mid-frame reset: assert `reset` during DATA bit 3 → `tx=1` in the same cycle, all counters 0. The byte is not resent after release.
- Parity build (`IO_UART_DRAIN_PARITY_EN`): send 0x07 → parity bit 1 precedes stop. Send 0x03 → parity bit 0. Frame is 44 cycles at CLKS_PER_BIT=4.
